// File: rtl/sdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdes_pkg
// Description : Shared widths, FSM state and output-FIFO entry layout for the
//               S-DES streaming front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package sdes_pkg;

    localparam int KEY_W = 10;
    localparam int BLK_W = 8;

    typedef enum logic [0:0] {
        NO_KEY = 1'b0,
        RUN    = 1'b1
    } state_t;

    typedef struct packed {
        logic             last;
        logic [BLK_W-1:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage
`default_nettype wire

// File: rtl/sdes.sv
`default_nettype none
// ============================================================================
// Module      : sdes
// Description : Combinational S-DES block encryption (two Feistel rounds).
// Revision    : 1.0 - initial release
// ============================================================================
module sdes
    import sdes_pkg::*;
(
    input  logic [BLK_W-1:0] i_pt,
    input  logic [KEY_W-1:0] i_key,
    output logic [BLK_W-1:0] o_ct
);

    function automatic logic [1:0] f_sbox0(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd7, 4'd8:          f_sbox0 = 2'd0;
            4'd0, 4'd6, 4'd10, 4'd13:  f_sbox0 = 2'd1;
            4'd3, 4'd5, 4'd9, 4'd15:   f_sbox0 = 2'd2;
            default:                   f_sbox0 = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] f_sbox1(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd5, 4'd9, 4'd11, 4'd14: f_sbox1 = 2'd0;
            4'd1, 4'd6, 4'd10, 4'd13:       f_sbox1 = 2'd1;
            4'd2, 4'd4, 4'd12:              f_sbox1 = 2'd2;
            default:                        f_sbox1 = 2'd3;
        endcase
    endfunction

    // Round function: expand/permute, key mix, S-boxes (row = outer bits), P4
    function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] sk);
        logic [7:0] x;
        logic [1:0] s0;
        logic [1:0] s1;
        x  = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
        s0 = f_sbox0({x[7], x[4], x[6], x[5]});
        s1 = f_sbox1({x[3], x[0], x[2], x[1]});
        f_round = {s0[0], s1[0], s1[1], s0[1]};
    endfunction

    function automatic logic [7:0] f_p8(input logic [9:0] v);
        f_p8 = {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
    endfunction

    logic [9:0] w_p10;
    logic [9:0] w_ls1;
    logic [9:0] w_ls2;
    logic [7:0] w_k1;
    logic [7:0] w_k2;
    logic [7:0] w_ip;
    logic [3:0] w_l1;
    logic [3:0] w_l2;
    logic [7:0] w_pre;

    assign w_p10 = {i_key[7], i_key[5], i_key[8], i_key[3], i_key[6],
                    i_key[0], i_key[9], i_key[1], i_key[2], i_key[4]};
    assign w_ls1 = {w_p10[8:5], w_p10[9], w_p10[3:0], w_p10[4]};
    assign w_ls2 = {w_ls1[7:5], w_ls1[9:8], w_ls1[2:0], w_ls1[4:3]};
    assign w_k1  = f_p8(w_ls1);
    assign w_k2  = f_p8(w_ls2);

    assign w_ip  = {i_pt[6], i_pt[2], i_pt[5], i_pt[7], i_pt[4], i_pt[0], i_pt[3], i_pt[1]};
    // Halves are swapped between rounds, so round two works on the original right half
    assign w_l1  = w_ip[7:4] ^ f_round(w_ip[3:0], w_k1);
    assign w_l2  = w_ip[3:0] ^ f_round(w_l1, w_k2);
    assign w_pre = {w_l2, w_l1};

    assign o_ct  = {w_pre[4], w_pre[7], w_pre[5], w_pre[3],
                    w_pre[1], w_pre[6], w_pre[0], w_pre[2]};

endmodule
`default_nettype wire

// File: rtl/sdes_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdes_byte_fifo
// Description : Synchronous power-of-two FIFO; head reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sdes_byte_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdes_cbc_stream.sv
`default_nettype none
// ============================================================================
// Module      : sdes_cbc_stream
// Description : Byte-stream S-DES encryptor with valid/ready in and out and an
//               output FIFO. Define SDES_CBC_EN for CBC chaining, else ECB.
// Revision    : 1.0 - initial release
// ============================================================================
module sdes_cbc_stream
    import sdes_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [9:0]       key_in,
    input  logic [7:0]       iv_in,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [7:0]       pt_data,
    input  logic             pt_last,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [7:0]       ct_data,
    output logic             ct_last,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             key_loaded
);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [KEY_W-1:0]            r_key;
    logic [CNT_W-1:0]            r_byte_cnt;
    logic                        w_accept;
    logic [BLK_W-1:0]            w_sdes_in;
    logic [BLK_W-1:0]            w_ct;
    fifo_entry_t                 w_push_entry;
    fifo_entry_t                 w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_unused_fifo_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NO_KEY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (key_load) begin
            w_state_nxt = RUN;
        end
    end

    assign pt_ready   = (r_state == RUN) && !w_full;
    assign w_accept   = pt_valid && pt_ready;
    assign key_loaded = (r_state == RUN);
    assign byte_cnt   = r_byte_cnt;

    // A key_load coinciding with an accept still encrypts that byte with the old key/chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key      <= '0;
            r_byte_cnt <= '0;
        end else if (key_load) begin
            r_key      <= key_in;
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

`ifdef SDES_CBC_EN
    logic [BLK_W-1:0] r_iv;
    logic [BLK_W-1:0] r_chain;

    assign w_sdes_in = pt_data ^ r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iv    <= '0;
            r_chain <= '0;
        end else if (key_load) begin
            r_iv    <= iv_in;
            r_chain <= iv_in;
        end else if (w_accept) begin
            r_chain <= pt_last ? r_iv : w_ct;
        end
    end
`else
    logic w_unused_iv;

    assign w_sdes_in   = pt_data;
    assign w_unused_iv = ^iv_in;
`endif

    sdes u_sdes (
        .i_pt  (w_sdes_in),
        .i_key (r_key),
        .o_ct  (w_ct)
    );

    assign w_push_entry = '{last: pt_last, data: w_ct};

    sdes_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_push_entry),
        .i_pop   (ct_ready),
        .o_dout  (w_head),
        .o_count (w_unused_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ct_valid = !w_empty;
    assign ct_data  = w_head.data;
    assign ct_last  = w_head.last;

endmodule
`default_nettype wire
